// File: rtl/cpu_consts.sv
// ----------------------------------------------------------------------------
// cpu_consts
//   Shared EXU constants: the exu_func_sel encodings of the divide family, the
//   divider sequencer state type and small op-decode helpers used by the
//   divider and its checker.
// ----------------------------------------------------------------------------
package cpu_consts;

    // exu_func_sel encodings routed to the iterative divider
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_DIVU = 4'd5;
    localparam logic [3:0] OP_REM  = 4'd6;
    localparam logic [3:0] OP_REMU = 4'd7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

    // Signed flavours; anything unrecognised decodes as unsigned (OP_DIVU)
    function automatic logic op_is_signed(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Remainder flavours; anything unrecognised returns the quotient
    function automatic logic op_is_rem(input logic [3:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic op_supported(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_sequencer_chk.sv
// ----------------------------------------------------------------------------
// div_sequencer_chk
//   Simulation checker for the divider request interface: a valid request
//   must carry one of the four divide encodings.
// Ports
//   clk, resetn   in  1  clock / async active-low reset
//   req_valid_i   in  1  request valid
//   op_i          in  4  exu_func_sel of the request
// ----------------------------------------------------------------------------
module div_sequencer_chk
    import cpu_consts::*;
(
    input logic       clk,
    input logic       resetn,
    input logic       req_valid_i,
    input logic [3:0] op_i
);

    a_op_supported: assert property (@(posedge clk) disable iff (!resetn)
        req_valid_i |-> op_supported(op_i));

endmodule

// File: rtl/div_sequencer_step.sv
// ----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division step on unsigned magnitudes.
//   {rem,quo} is shifted left one place; if the shifted remainder is at least
//   the divisor it is reduced and a 1 enters the quotient LSB, else a 0.
// Ports
//   rem       in   XLEN  partial remainder (always < dvsr between steps)
//   quo       in   XLEN  dividend bits still to consume / quotient bits so far
//   dvsr      in   XLEN  divisor magnitude
//   rem_next  out  XLEN  partial remainder after this step
//   quo_next  out  XLEN  quotient register after this step
// ----------------------------------------------------------------------------
module div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] dvsr,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    // One extra bit: the shifted remainder can reach 2*dvsr-1, which overflows
    // XLEN when the divisor has its top bit set.
    logic [XLEN:0] rem_sh_s;
    logic [XLEN:0] diff_s;

    // Shift, trial-subtract and restore
    always_comb begin
        rem_sh_s = {rem, quo[XLEN-1]};
        diff_s   = rem_sh_s - {1'b0, dvsr};
        if (rem_sh_s >= {1'b0, dvsr}) begin
            rem_next = diff_s[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = rem_sh_s[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// ----------------------------------------------------------------------------
// div_sequencer
//   Iterative radix-2 restoring divider with its sequencing FSM
//   (IDLE -> PREP -> ITER -> FIX -> DONE). Handles DIV/DIVU/REM/REMU and
//   their 32-bit word variants (result sign-extended from bit 31).
//   Signed ops divide magnitudes and fix up signs in FIX; divide-by-zero and
//   signed overflow are flagged in PREP and override the result in FIX.
//   Latency without early-out: N iterations (N = XLEN or 32) plus PREP and
//   FIX, so resp_valid_o rises N+3 cycles counting the accept cycle.
//   XLEN must be greater than 32.
// Configuration
//   DIV_EARLY_OUT_EN : when defined, PREP skips ITER for div-by-zero,
//   overflow and |divisor| > |dividend|; results are identical, only the
//   latency drops to 3 cycles.
// Ports
//   clk            in   1     clock
//   resetn         in   1     async active-low reset
//   req_valid_i    in   1     divide request valid
//   req_ready_o    out  1     accept possible (IDLE and no kill)
//   op_i           in   4     exu_func_sel (OP_DIV/OP_DIVU/OP_REM/OP_REMU)
//   word_op_i      in   1     32-bit op
//   rs1_i          in   XLEN  dividend
//   rs2_i          in   XLEN  divisor
//   kill_i         in   1     squash in-flight op, no response
//   resp_valid_o   out  1     result valid, held until taken
//   resp_ready_i   in   1     consumer takes result
//   result_o       out  XLEN  quotient or remainder
//   busy_o         out  1     sequencer not idle
// ----------------------------------------------------------------------------
module div_sequencer
    import cpu_consts::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [3:0]      op_i,
    input  logic            word_op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            kill_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_XLEN = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(32);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    div_state_t      state_r;
    div_state_t      state_nxt_s;

    // Request captured at accept
    logic [3:0]      op_r;
    logic            word_op_r;
    logic [XLEN-1:0] rs1_r;
    logic [XLEN-1:0] rs2_r;

    // Prepared operands and flags
    logic            neg_q_r;
    logic            neg_r_r;
    logic            div0_r;
    logic            ovf_r;
    logic [XLEN-1:0] dvnd_r;
    logic [XLEN-1:0] dvsr_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] quo_r;
    logic [CNT_W-1:0] cnt_r;

    logic [XLEN-1:0] result_r;
    logic            resp_valid_r;
    logic            busy_r;

    logic            req_ready_s;
    logic            accept_s;
    logic            op_signed_s;
    logic            op_rem_s;
    logic [XLEN-1:0] opa_s;
    logic [XLEN-1:0] opb_s;
    logic [XLEN-1:0] min_s;
    logic            sa_s;
    logic            sb_s;
    logic [XLEN-1:0] mag_a_s;
    logic [XLEN-1:0] mag_b_s;
    logic            div0_s;
    logic            ovf_s;
    logic [XLEN-1:0] quo_init_s;
    logic [CNT_W-1:0] cnt_init_s;
    logic            early_s;
    logic [XLEN-1:0] step_rem_s;
    logic [XLEN-1:0] step_quo_s;
    logic [XLEN-1:0] q_adj_s;
    logic [XLEN-1:0] r_adj_s;
    logic [XLEN-1:0] fix_q_s;
    logic [XLEN-1:0] fix_r_s;
    logic [XLEN-1:0] fix_sel_s;
    logic [XLEN-1:0] fix_result_s;

    assign req_ready_s  = (state_r == IDLE) && !kill_i;
    assign accept_s     = req_valid_i && req_ready_s;
    assign req_ready_o  = req_ready_s;
    assign resp_valid_o = resp_valid_r;
    assign result_o     = result_r;
    assign busy_o       = busy_r;

    // Operand preparation from the latched request (consumed in PREP)
    always_comb begin
        op_signed_s = op_is_signed(op_r);
        op_rem_s    = op_is_rem(op_r);
        if (word_op_r) begin
            if (op_signed_s) begin
                opa_s = {{(XLEN-32){rs1_r[31]}}, rs1_r[31:0]};
                opb_s = {{(XLEN-32){rs2_r[31]}}, rs2_r[31:0]};
            end else begin
                opa_s = {{(XLEN-32){1'b0}}, rs1_r[31:0]};
                opb_s = {{(XLEN-32){1'b0}}, rs2_r[31:0]};
            end
            // 32-bit MIN as it appears after sign extension
            min_s      = {{(XLEN-31){1'b1}}, {31{1'b0}}};
            cnt_init_s = CNT_WORD;
        end else begin
            opa_s      = rs1_r;
            opb_s      = rs2_r;
            min_s      = {1'b1, {(XLEN-1){1'b0}}};
            cnt_init_s = CNT_XLEN;
        end
        sa_s    = op_signed_s & opa_s[XLEN-1];
        sb_s    = op_signed_s & opb_s[XLEN-1];
        mag_a_s = sa_s ? ('0 - opa_s) : opa_s;
        mag_b_s = sb_s ? ('0 - opb_s) : opb_s;
        div0_s  = (opb_s == '0);
        ovf_s   = op_signed_s && (opa_s == min_s) && (opb_s == '1);
        // Word magnitudes fit in 32 bits; park them at the top so that 32
        // shifts consume them and leave a zero-extended quotient behind.
        if (word_op_r) begin
            quo_init_s = {mag_a_s[31:0], {(XLEN-32){1'b0}}};
        end else begin
            quo_init_s = mag_a_s;
        end
    end

`ifdef DIV_EARLY_OUT_EN
    // Trivial divisions whose result FIX can form without iterating
    assign early_s = div0_s | ovf_s | (mag_b_s > mag_a_s);
`else
    assign early_s = 1'b0;
`endif

    div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .dvsr     (dvsr_r),
        .rem_next (step_rem_s),
        .quo_next (step_quo_s)
    );

    // Sign fix-up, special-case overrides and word sign extension
    always_comb begin
        q_adj_s = neg_q_r ? ('0 - quo_r) : quo_r;
        r_adj_s = neg_r_r ? ('0 - rem_r) : rem_r;
        if (div0_r) begin
            fix_q_s = '1;
            fix_r_s = dvnd_r;
        end else if (ovf_r) begin
            fix_q_s = dvnd_r;
            fix_r_s = '0;
        end else begin
            fix_q_s = q_adj_s;
            fix_r_s = r_adj_s;
        end
        fix_sel_s = op_rem_s ? fix_r_s : fix_q_s;
        if (word_op_r) begin
            fix_result_s = {{(XLEN-32){fix_sel_s[31]}}, fix_sel_s[31:0]};
        end else begin
            fix_result_s = fix_sel_s;
        end
    end

    // Next-state logic; a kill returns any busy state to IDLE
    always_comb begin
        state_nxt_s = state_r;
        if (kill_i && (state_r != IDLE)) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_nxt_s = PREP;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                PREP: begin
                    if (early_s) begin
                        state_nxt_s = FIX;
                    end else begin
                        state_nxt_s = ITER;
                    end
                end
                ITER: begin
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = FIX;
                    end else begin
                        state_nxt_s = ITER;
                    end
                end
                FIX: begin
                    state_nxt_s = DONE;
                end
                DONE: begin
                    if (resp_ready_i) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: capture, prepare, iterate and form the result
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_r      <= 4'd0;
            word_op_r <= 1'b0;
            rs1_r     <= '0;
            rs2_r     <= '0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            div0_r    <= 1'b0;
            ovf_r     <= 1'b0;
            dvnd_r    <= '0;
            dvsr_r    <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            cnt_r     <= '0;
            result_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r      <= op_i;
                        word_op_r <= word_op_i;
                        rs1_r     <= rs1_i;
                        rs2_r     <= rs2_i;
                    end
                end
                PREP: begin
                    neg_q_r <= sa_s ^ sb_s;
                    neg_r_r <= sa_s;
                    div0_r  <= div0_s;
                    ovf_r   <= ovf_s;
                    dvnd_r  <= opa_s;
                    dvsr_r  <= mag_b_s;
                    cnt_r   <= cnt_init_s;
                    if (early_s) begin
                        // q = 0, r = |dividend|; sign fix-up in FIX restores r
                        rem_r <= mag_a_s;
                        quo_r <= '0;
                    end else begin
                        rem_r <= '0;
                        quo_r <= quo_init_s;
                    end
                end
                ITER: begin
                    rem_r <= step_rem_s;
                    quo_r <= step_quo_s;
                    cnt_r <= cnt_r - CNT_LAST;
                end
                FIX: begin
                    // A squashed op must not disturb the visible result
                    if (!kill_i) begin
                        result_r <= fix_result_s;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Registered status outputs, derived from the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            resp_valid_r <= (state_nxt_s == DONE);
            busy_r       <= (state_nxt_s != IDLE);
        end
    end

    div_sequencer_chk u_chk (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid_i (req_valid_i),
        .op_i        (op_i)
    );

endmodule

// File: tb/tb_div_sequencer.sv
// ----------------------------------------------------------------------------
// tb_div_sequencer
//   Directed self-checking bench for div_sequencer (XLEN = 64): results and
//   latencies of hand-computed vectors, back-pressure in DONE, kill handling
//   and asynchronous reset during iteration.
// ----------------------------------------------------------------------------
module tb_div_sequencer;
    import cpu_consts::*;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY_BUILD = 1'b1;
`else
    localparam bit EARLY_BUILD = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  op;
    logic        word_op;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        kill;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] result;
    logic        busy;

    int checks_cnt;
    int errors_cnt;

    div_sequencer #(
        .XLEN (64)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .op_i         (op),
        .word_op_i    (word_op),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .kill_i       (kill),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .result_o     (result),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence itself gets stuck
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op, check latency/result, optionally hold off the consumer
    task automatic run_op(input string tag, input logic [3:0] f, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input int n,
                          input bit early_case, input int hold);
        int lat;
        int exp_lat;
        exp_lat = (EARLY_BUILD && early_case) ? 3 : n + 3;
        req_valid = 1'b1;
        op        = f;
        word_op   = w;
        rs1       = a;
        rs2       = b;
        #1;
        check_val({tag, "_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rs1       = {$urandom, $urandom};
        rs2       = {$urandom, $urandom};
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_res"}, result, exp_res);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_val({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
            check_val({tag, "_hold_res"}, result, exp_res);
            check_val({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check_val({tag, "_taken_valid"}, 64'(resp_valid), 64'd0);
        check_val({tag, "_taken_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit seen;
        checks_cnt = 0;
        errors_cnt = 0;
        resetn     = 1'b0;
        req_valid  = 1'b0;
        op         = OP_DIVU;
        word_op    = 1'b0;
        rs1        = 64'd0;
        rs2        = 64'd0;
        kill       = 1'b0;
        resp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", 64'(resp_valid), 64'd0);
        check_val("rst_result", result, 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        run_op("divu_100_7", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 64, 1'b0, 0);
        run_op("remu_100_7", OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 64, 1'b0, 0);
        run_op("div_m7_2", OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 64, 1'b0, 0);
        run_op("rem_m7_2", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0, 0);
        run_op("divw_ovf", OP_DIV, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 32, 1'b1, 0);
        run_op("div_5_0", OP_DIV, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1, 0);
        run_op("remu_5_0", OP_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 64, 1'b1, 0);
        run_op("rem_min_m1", OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 64, 1'b1, 0);
        // Word ops ignore the upper operand halves
        run_op("divuw_100_7", OP_DIVU, 1'b1, 64'h0000_0001_0000_0064, 64'hABCD_0000_0000_0007,
               64'd14, 32, 1'b0, 0);
        run_op("divw_m7_2", OP_DIV, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'h0000_0000_0000_0002,
               64'hFFFF_FFFF_FFFF_FFFD, 32, 1'b0, 0);
        // Divisor with the top bit set: shifted remainder needs the extra bit
        run_op("divu_big", OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
               64'd1, 64, 1'b0, 0);
        run_op("remu_big", OP_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
               64'h7FFF_FFFF_FFFF_FFFF, 64, 1'b0, 5);

        // Kill during ITER: no response, sequencer idles next edge
        req_valid = 1'b1;
        op        = OP_DIVU;
        word_op   = 1'b0;
        rs1       = 64'd100;
        rs2       = 64'd7;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_val("kill_busy_before", 64'(busy), 64'd1);
        kill = 1'b1;
        #1;
        check_val("kill_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        kill = 1'b0;
        check_val("kill_busy_after", 64'(busy), 64'd0);
        check_val("kill_valid_after", 64'(resp_valid), 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1'b1;
        end
        check_val("kill_no_resp", 64'(seen), 64'd0);
        run_op("divu_9_3", OP_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 64, 1'b0, 0);

        // Kill alongside a request in IDLE: not accepted
        req_valid = 1'b1;
        kill      = 1'b1;
        #1;
        check_val("kill_idle_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        kill      = 1'b0;
        check_val("kill_idle_busy", 64'(busy), 64'd0);

        // Async reset mid-ITER clears outputs without waiting for a clock
        req_valid = 1'b1;
        op        = OP_DIVU;
        rs1       = 64'd100;
        rs2       = 64'd7;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_val("areset_valid", 64'(resp_valid), 64'd0);
        check_val("areset_busy", 64'(busy), 64'd0);
        check_val("areset_result", result, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        run_op("divu_3_10", OP_DIVU, 1'b0, 64'd3, 64'd10, 64'd0, 64, 1'b1, 0);
        run_op("remu_3_10", OP_REMU, 1'b0, 64'd3, 64'd10, 64'd3, 64, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
